pwm_generator: RTL

PWM_GENERATOR -- requirements
Module: pwm_generator

---
 rtl/pwm_pkg.sv | 13 +
 rtl/pwm_generator_edge_detect.sv | 27 ++
 rtl/pwm_generator.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM generator.
//   PWM_WIDTH   - default width of the period/duty counters and config fields
//   pwm_state_e - controller state (IDLE, RUN)
package pwm_pkg;

  localparam int unsigned PWM_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_e;

endpackage

// File: rtl/pwm_generator_edge_detect.sv
// edge_detect: single-clock rising-edge detector for a level synchronous to clk.
//   clk  - system clock
//   rst  - asynchronous active-low reset
//   in   - level input (divided clock)
//   rise - high for the one clk where in is high and its registered copy is low
// The registered copy resets to 1 so that an input already high when reset
// releases does not count as an edge.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic r_in_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_d <= 1'b1;
    end else begin
      r_in_d <= in;
    end
  end

  assign rise = in & ~r_in_d;

endmodule

// File: rtl/pwm_generator.sv
// pwm_generator: PWM waveform generator stepped by a divided clock.
//   clk         - system clock, all state changes on its rising edge
//   rst         - asynchronous active-low reset
//   tick_in     - divided clock; each rising edge is one PWM step
//   enable      - high runs the PWM, low idles it
//   cfg_valid   - new period/duty offered
//   cfg_ready   - a configuration can be accepted (no config pending)
//   cfg_period  - period length minus one, in steps
//   cfg_duty    - high time, in steps
//   pwm_out     - PWM waveform, straight from a flop
//   period_done - one-clk pulse at each period wrap
module pwm_generator
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_duty,
  output logic             pwm_out,
  output logic             period_done
);

  logic             w_step;
  logic             w_xfer;
  logic             w_wrap;
  logic             w_apply;

  pwm_state_e       r_state;
  pwm_state_e       w_state_next;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_next;
  logic [WIDTH-1:0] r_period_act;
  logic [WIDTH-1:0] w_period_next;
  logic [WIDTH-1:0] r_duty_act;
  logic [WIDTH-1:0] w_duty_next;
  logic [WIDTH-1:0] r_sh_period;
  logic [WIDTH-1:0] r_sh_duty;
  logic             r_pending;
  logic             w_pending_next;
  logic             r_pwm;
  logic             w_pwm_next;
  logic             r_done;
  logic             w_done_next;

  edge_detect u_edge_detect (
    .clk  (clk),
    .rst  (rst),
    .in   (tick_in),
    .rise (w_step)
  );

  assign cfg_ready   = ~r_pending;
  assign w_xfer      = cfg_valid & ~r_pending;
  assign pwm_out     = r_pwm;
  assign period_done = r_done;

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_period_next  = r_period_act;
    w_duty_next    = r_duty_act;
    w_pending_next = r_pending;
    w_wrap         = 1'b0;
    w_apply        = 1'b0;

    unique case (r_state)
      IDLE: begin
        // Steps are ignored here; a pending config is taken on the next clk.
        w_cnt_next = '0;
        w_apply    = r_pending;
        if (enable) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        // Dropping enable takes priority over a coincident step, so an
        // aborted period never produces a period_done pulse.
        if (!enable) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (w_step) begin
          if (r_cnt == r_period_act) begin
            w_wrap     = 1'b1;
            w_cnt_next = '0;
            w_apply    = r_pending;
          end else begin
            w_cnt_next = r_cnt + WIDTH'(1);
          end
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase

    // Apply needs pending set and transfer needs it clear, so both never
    // happen in the same clk; a transfer on a wrap clk waits for the next wrap.
    if (w_apply) begin
      w_period_next  = r_sh_period;
      w_duty_next    = r_sh_duty;
      w_pending_next = 1'b0;
    end
    if (w_xfer) begin
      w_pending_next = 1'b1;
    end

    w_done_next = w_wrap;
    // Compare against the post-edge count and duty so the waveform follows
    // a newly applied config on the very wrap that loads it.
    w_pwm_next  = (w_state_next == RUN) && (w_cnt_next < w_duty_next);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_period_act <= '1;
      r_duty_act   <= '0;
      r_sh_period  <= '0;
      r_sh_duty    <= '0;
      r_pending    <= 1'b0;
      r_pwm        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_period_act <= w_period_next;
      r_duty_act   <= w_duty_next;
      r_pending    <= w_pending_next;
      r_pwm        <= w_pwm_next;
      r_done       <= w_done_next;
      if (w_xfer) begin
        r_sh_period <= cfg_period;
        r_sh_duty   <= cfg_duty;
      end
    end
  end

endmodule
